fft_frame_tx: RTL and testbench

FFT_FRAME_TX -- requirements
Module: fft_frame_tx

---
 rtl/fft_frame_tx.sv | 168 ++++++++++++++++
 tb/tb_fft_frame_tx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_tx.sv
// -----------------------------------------------------------------------------
// fft_frame_tx
// Double-buffered frame transmitter that feeds an FFT input port. Upstream
// samples are collected into one of two 16-entry banks. Each full bank is
// pushed out one sample per cycle. The FFT's stall input is honoured with a
// one-cycle skid.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : synchronous, active-high reset
//   s_valid        : upstream sample valid
//   s_ready        : block accepts a sample this cycle (combinational)
//   s_real, s_imag : upstream sample, 16 bits each
//   push_stall     : stall from downstream FFT input port
//   out_push_F     : registered push, one sample per high cycle
//   out_real_F     : registered sample, real part (holds when no push)
//   out_imag_F     : registered sample, imaginary part (holds when no push)
//   frames_sent_F  : registered count of fully transmitted frames (wraps)
//
// Configuration
//   FFT_TX_BITREV_EN : when defined, each bank is read in bit-reversed index
//                      order. Otherwise it is read in natural order 0..15.
// -----------------------------------------------------------------------------
module fft_frame_tx (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_real,
    input  logic [15:0] s_imag,
    input  logic        push_stall,
    output logic        out_push_F,
    output logic [15:0] out_real_F,
    output logic [15:0] out_imag_F,
    output logic [7:0]  frames_sent_F
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    // Entry {bank, index}: real in [31:16], imag in [15:0].
    logic [31:0] mem_r [0:31];

    logic        wb_r;
    logic        rb_r;
    logic [1:0]  full_r;
    logic [3:0]  wi_r;
    logic [3:0]  ri_r;

    logic        accept_s;
    logic        wr_done_s;
    logic        issue_s;
    logic        rd_done_s;
    logic [1:0]  full_nxt_s;
    logic [3:0]  addr_s;

    // Map the read index to a bank address.
    function automatic logic [3:0] rd_addr(input logic [3:0] idx);
`ifdef FFT_TX_BITREV_EN
        rd_addr = {idx[0], idx[1], idx[2], idx[3]};
`else
        rd_addr = idx;
`endif
    endfunction

    // Handshake, issue decisions and the next value of the bank-full flags.
    always_comb begin
        s_ready    = 1'b0;
        full_nxt_s = full_r;
        if (reset) begin
            s_ready = 1'b0;
        end else begin
            s_ready = ~full_r[wb_r];
        end
        accept_s  = s_valid & s_ready;
        wr_done_s = accept_s & (wi_r == 4'd15);
        issue_s   = full_r[rb_r] & ~push_stall;
        rd_done_s = issue_s & (ri_r == 4'd15);
        addr_s    = rd_addr(ri_r);
        // A write completion and a read release never target the same bank
        // at one edge, so both updates can be applied independently.
        if (wr_done_s) begin
            full_nxt_s[wb_r] = 1'b1;
        end else begin
            full_nxt_s[wb_r] = full_r[wb_r];
        end
        if (rd_done_s) begin
            full_nxt_s[rb_r] = 1'b0;
        end else begin
            full_nxt_s[rb_r] = full_nxt_s[rb_r];
        end
    end

    // Read FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rd_done_s) begin
                    state_nxt_s = full_nxt_s[~rb_r] ? ST_SEND : ST_IDLE;
                end else if (issue_s) begin
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (rd_done_s) begin
                    state_nxt_s = full_nxt_s[~rb_r] ? ST_SEND : ST_IDLE;
                end else if (full_r[rb_r]) begin
                    // Covers both an active issue and a stalled frame.
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Sample storage. Contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[{wb_r, wi_r}] <= {s_real, s_imag};
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            wb_r          <= 1'b0;
            rb_r          <= 1'b0;
            full_r        <= 2'b00;
            wi_r          <= 4'd0;
            ri_r          <= 4'd0;
            out_push_F    <= 1'b0;
            out_real_F    <= 16'd0;
            out_imag_F    <= 16'd0;
            frames_sent_F <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            full_r  <= full_nxt_s;
            if (accept_s) begin
                wi_r <= wr_done_s ? 4'd0 : wi_r + 4'd1;
                if (wr_done_s) begin
                    wb_r <= ~wb_r;
                end
            end
            out_push_F <= issue_s;
            if (issue_s) begin
                out_real_F <= mem_r[{rb_r, addr_s}][31:16];
                out_imag_F <= mem_r[{rb_r, addr_s}][15:0];
                ri_r       <= rd_done_s ? 4'd0 : ri_r + 4'd1;
                if (rd_done_s) begin
                    rb_r          <= ~rb_r;
                    frames_sent_F <= frames_sent_F + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_tx
// Self-checking bench for fft_frame_tx. The reference model keeps accepted
// samples in queues. The queue part_q holds the frame being collected. The
// queue frm_q holds the complete frames that are not yet released, at most
// two. The model pushes out the oldest complete frame in address order.
// -----------------------------------------------------------------------------
module tb_fft_frame_tx;

    logic        clk = 1'b0;
    logic        reset, s_valid, push_stall;
    logic        s_ready;
    logic [15:0] s_real, s_imag;
    logic        out_push_F;
    logic [15:0] out_real_F, out_imag_F;
    logic [7:0]  frames_sent_F;

    fft_frame_tx dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_real(s_real), .s_imag(s_imag), .push_stall(push_stall),
        .out_push_F(out_push_F), .out_real_F(out_real_F),
        .out_imag_F(out_imag_F), .frames_sent_F(frames_sent_F)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] part_q[$];
    logic [31:0] frm_q[$];
    int          sidx = 0;
    logic        exp_push = 1'b0;
    logic [15:0] exp_re = 16'd0, exp_im = 16'd0;
    logic [7:0]  exp_frames = 8'd0;
    int          cyc = 0;
    bit          last_acc = 1'b0;

    wire [41:0] obs = {out_push_F, out_real_F, out_imag_F, frames_sent_F, s_ready};

    function automatic int perm(input int i);
        int r;
        r = i;
`ifdef FFT_TX_BITREV_EN
        r = 0;
        for (int b = 0; b < 4; b++) if (((i >> b) % 2) == 1) r = r + (8 >> b);
`endif
        return r;
    endfunction

    function automatic logic [41:0] expv();
        logic rdy;
        rdy = (reset === 1'b0) && (frm_q.size() < 32);
        return {exp_push, exp_re, exp_im, exp_frames, rdy};
    endfunction

    // advance one clock, updating the model with the inputs seen at the edge
    task automatic tick();
        bit iss, acc;
        logic [31:0] smp;
        iss = !reset && (frm_q.size() >= 16) && !push_stall;
        acc = !reset && s_valid && (frm_q.size() < 32);
        smp = {s_real, s_imag};
        @(posedge clk);
        cyc++;
        last_acc = acc;
        if (reset) begin
            part_q.delete(); frm_q.delete();
            sidx = 0; exp_push = 1'b0; exp_re = 16'd0; exp_im = 16'd0; exp_frames = 8'd0;
        end else begin
            exp_push = iss;
            if (iss) begin
                {exp_re, exp_im} = frm_q[perm(sidx)];
                sidx++;
                if (sidx == 16) begin
                    for (int k = 0; k < 16; k++) void'(frm_q.pop_front());
                    sidx = 0;
                    exp_frames = exp_frames + 8'd1;
                end
            end
            if (acc) begin
                part_q.push_back(smp);
                if (part_q.size() == 16) begin
                    for (int k = 0; k < 16; k++) frm_q.push_back(part_q[k]);
                    part_q.delete();
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; s_valid = 1'b0; push_stall = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic rand_sample();
        s_real = 16'($urandom); s_imag = 16'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b1; push_stall = 1'b0; rand_sample();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs !== {1'b0, 16'd0, 16'd0, 8'd0, 1'b0}) begin
                errors++; $display("FAIL reset_state cyc=%0d got=%h exp=%h", cyc, obs, 42'd0);
            end
        end
        reset = 1'b0; s_valid = 1'b0;
        tick();
        checks++;
        if (obs !== expv()) begin errors++; $display("FAIL reset_release got=%h exp=%h", obs, expv()); end
    endtask

    task automatic test_basic();
        int npush = 0, first = -1, lastp = -1, lacc = -1;
        do_reset();
        for (int k = 0; k < 36; k++) begin
            s_valid = (k < 16); s_real = 16'(k); s_imag = 16'(-k);
            tick();
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL basic cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
            if (last_acc) lacc = cyc;
            if (out_push_F) begin npush++; lastp = cyc; if (first < 0) first = cyc; end
        end
        checks++;
        if (npush != 16) begin errors++; $display("FAIL basic_count got=%0d exp=16", npush); end
        checks++;
        if (first != lacc + 1) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", first, lacc + 1); end
        checks++;
        if (lastp - first != 15) begin errors++; $display("FAIL basic_contig got=%0d exp=15", lastp - first); end
        checks++;
        if (frames_sent_F !== 8'd1) begin errors++; $display("FAIL basic_frames got=%0d exp=1", frames_sent_F); end
    endtask

    task automatic test_stall();
        int npush = 0, guard = 0;
        do_reset();
        s_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin rand_sample(); tick(); end
        s_valid = 1'b0;
        while (npush < 6 && guard < 40) begin
            tick(); guard++;
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL stall_pre cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
            if (out_push_F) npush++;
        end
        // the 6th push is visible now; it is the skid push
        push_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_push_F !== 1'b0 || obs !== expv()) begin
                errors++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, obs, expv());
            end
            if (out_push_F) npush++;
        end
        push_stall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL stall_post cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
            if (out_push_F) npush++;
        end
        checks++;
        if (npush != 16) begin errors++; $display("FAIL stall_count got=%0d exp=16", npush); end
    endtask

    task automatic test_backpressure();
        int nacc = 0, npush = 0, first = -1, lastp = -1, rdy_cyc = -1;
        do_reset();
        push_stall = 1'b1;
        for (int i = 0; i < 48; i++) begin
            s_valid = 1'b1; rand_sample();
            tick();
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL bp_fill cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
            if (last_acc) nacc++;
            if (out_push_F) npush++;
        end
        s_valid = 1'b0;
        checks++;
        if (nacc != 32 || npush != 0 || s_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full got acc=%0d push=%0d rdy=%b exp acc=32 push=0 rdy=0", nacc, npush, s_ready);
        end
        push_stall = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL bp_drain cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
            if (out_push_F) begin npush++; lastp = cyc; if (first < 0) first = cyc; end
            if (s_ready && rdy_cyc < 0) rdy_cyc = cyc;
        end
        checks++;
        if (npush != 32 || lastp - first != 31) begin
            errors++; $display("FAIL bp_contig got n=%0d span=%0d exp n=32 span=31", npush, lastp - first);
        end
        checks++;
        if (rdy_cyc != first + 15) begin errors++; $display("FAIL bp_ready got=%0d exp=%0d", rdy_cyc, first + 15); end
    endtask

    task automatic test_reset_mid();
        int npush = 0;
        do_reset();
        s_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin rand_sample(); tick(); end
        reset = 1'b1; tick(); reset = 1'b0;
        for (int k = 0; k < 16; k++) begin s_real = 16'(100 + k); s_imag = 16'($urandom); tick(); end
        s_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL rmid_w cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
            if (out_push_F) npush++;
        end
        checks++;
        if (npush != 16 || frames_sent_F !== 8'd1) begin
            errors++; $display("FAIL rmid_w_sum got n=%0d f=%0d exp n=16 f=1", npush, frames_sent_F);
        end
        // reset while a frame is being pushed out
        s_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin rand_sample(); tick(); end
        s_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        npush = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL rmid_r cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
            if (out_push_F) npush++;
        end
        checks++;
        if (npush != 0) begin errors++; $display("FAIL rmid_r_push got=%0d exp=0", npush); end
    endtask

    task automatic test_stream();
        int total = 257 * 16;
        int nacc = 0, npush = 0, first = -1, lastp = -1, guard = 0;
        do_reset();
        while (npush < total && guard < total + 200) begin
            s_valid = (nacc < total); rand_sample();
            tick(); guard++;
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
            if (last_acc) nacc++;
            if (out_push_F) begin npush++; lastp = cyc; if (first < 0) first = cyc; end
        end
        s_valid = 1'b0;
        checks++;
        if (npush != total || lastp - first + 1 != total) begin
            errors++; $display("FAIL stream_contig got n=%0d span=%0d exp %0d", npush, lastp - first + 1, total);
        end
        checks++;
        if (frames_sent_F !== 8'd1) begin errors++; $display("FAIL stream_wrap got=%0d exp=1", frames_sent_F); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            s_valid    = ($urandom_range(0, 3) != 0);
            push_stall = ($urandom_range(0, 3) == 0);
            reset      = ($urandom_range(0, 299) == 0);
            rand_sample();
            tick();
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
        end
        reset = 1'b0; push_stall = 1'b0; s_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; s_valid = 1'b0; push_stall = 1'b0; s_real = 16'd0; s_imag = 16'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_backpressure();
        test_reset_mid();
        test_stream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
